// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port main_memory; one access at a time, read data returned with a one-cycle ack.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round robin.
module mem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [1:0]        dbg_state
);

  // Requester handshake: reqN is held with stable we/addr/wdata until ackN.
  // A request is sampled only in IDLE; ackN pulses for exactly one cycle in DONE.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic                owner;
  logic                we_l;
  logic [ADDR_W-1:0]   addr_l;
  logic [DATA_W-1:0]   wdata_l;
  logic                grant_port;
  logic                start;

  assign start = req0 | req1;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign grant_port = ~req0;
`else
  logic rr_last;
  // On a tie the port that was not served last wins.
  assign grant_port = (req0 & req1) ? ~rr_last : req1;

  always_ff @(posedge clk) begin
    if (reset)              rr_last <= 1'b1;
    else if (state == DONE) rr_last <= owner;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCESS;
      ACCESS:  state_nxt = we_l ? DONE : RD_WAIT;
      RD_WAIT: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner   <= 1'b0;
      we_l    <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      if (state == IDLE && start) begin
        owner   <= grant_port;
        we_l    <= grant_port ? we1 : we0;
        addr_l  <= grant_port ? addr1 : addr0;
        wdata_l <= grant_port ? wdata1 : wdata0;
      end
      if (state == RD_WAIT) begin
        if (owner) rdata1 <= mem_data_out;
        else       rdata0 <= mem_data_out;
      end
    end
  end

  // Reset gates the decode so nothing is issued or acked in the reset cycle.
  always_comb begin
    mem_address      = addr_l;
    mem_data_in      = wdata_l;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    ack0             = 1'b0;
    ack1             = 1'b0;
    busy             = 1'b0;
    dbg_state        = state;
    if (!reset) begin
      busy = (state != IDLE);
      case (state)
        ACCESS: begin
          mem_write_enable = we_l;
          mem_read_enable  = ~we_l;
        end
        DONE: begin
          ack0 = ~owner;
          ack1 = owner;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory model, driver tasks, and a scoreboard monitor
// that pops expected {port, is_read, data} entries on every ack.
module tb_mem_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int W      = 18;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic              ack0, ack1, busy, mem_write_enable, mem_read_enable;
  logic [DATA_W-1:0] rdata0, rdata1, mem_data_in;
  logic [DATA_W-1:0] mem_data_out = '0;
  logic [ADDR_W-1:0] mem_address;
  logic [1:0]        dbg_state;

  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] mem [0:255];
  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;

  mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_data_out(mem_data_out), .dbg_state(dbg_state)
  );

  // Clock / cycle counter / memory model with one-cycle read latency.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write_enable) mem[mem_address[7:0]] <= mem_data_in;
    if (mem_read_enable)  mem_data_out <= mem[mem_address[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    logic [W-1:0] e;
    chk("en_exclusive", {31'd0, mem_write_enable & mem_read_enable}, 32'd0);
    if (ack0 && ack1) note_fail("double_ack");
    else if (ack0 || ack1) begin
      if (exp_q.size() == 0) note_fail("unexpected_ack");
      else begin
        e = exp_q.pop_front();
        chk("ack_port", {31'd0, ack1}, {31'd0, e[17]});
        if (e[16]) chk("rdata", ack1 ? rdata1 : rdata0, {16'd0, e[15:0]});
      end
    end
  end

  task automatic set_port(input bit port, input bit rq, input bit we,
                          input logic [15:0] addr, input logic [15:0] data);
    if (port) begin req1 = rq; we1 = we; addr1 = addr; wdata1 = data; end
    else      begin req0 = rq; we0 = we; addr0 = addr; wdata0 = data; end
  endtask

  // Single access on an otherwise idle arbiter; checks the ACCESS cycle and ack latency.
  task automatic access(input bit port, input bit we, input logic [15:0] addr,
                        input logic [15:0] data, input logic [15:0] rd_exp);
    int t0;
    bit seen;
    exp_q.push_back({port, ~we, we ? 16'h0000 : rd_exp});
    @(posedge clk); #1;
    set_port(port, 1'b1, we, addr, data);
    t0 = cyc;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (cyc == t0 + 1) begin
        chk("acc_wen",  {31'd0, mem_write_enable}, {31'd0, we});
        chk("acc_ren",  {31'd0, mem_read_enable},  {31'd0, ~we});
        chk("acc_addr", {16'd0, mem_address}, {16'd0, addr});
        if (we) chk("acc_wdata", {16'd0, mem_data_in}, {16'd0, data});
      end
      if (port ? ack1 : ack0) begin
        seen = 1;
        chk("latency", cyc - t0, we ? 32'd2 : 32'd3);
      end
    end
    if (!seen) note_fail("ack_timeout");
    @(posedge clk); #1;
    set_port(port, 1'b0, 1'b0, addr, data);
  endtask

  initial begin
    int t0, n, last;
    bit seen;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h20] = 16'h1234;
    mem[8'h30] = 16'hAAAA;
    mem[8'h40] = 16'h1111;
    mem[8'h41] = 16'h2222;

    // 1: reset, idle for 10 cycles
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_rdata0", {16'd0, rdata0}, 32'd0);
    chk("rst_rdata1", {16'd0, rdata1}, 32'd0);
    chk("rst_addr",   {16'd0, mem_address}, 32'd0);
    chk("rst_wdata",  {16'd0, mem_data_in}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("idle_outs", {27'd0, busy, mem_write_enable, mem_read_enable, ack0, ack1}, 32'd0);
      @(negedge clk);
    end

    // 2: port 0 write then read back
    access(1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000);
    access(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);

    // 4: port 1 read while port 0 idle; port 0 state untouched
    access(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234);
    chk("rdata0_kept", {16'd0, rdata0}, 32'h0000BEEF);
    access(1'b1, 1'b1, 16'h0050, 16'h7777, 16'h0000);
    access(1'b0, 1'b0, 16'h0050, 16'h0000, 16'h7777);
    chk("rdata1_kept", {16'd0, rdata1}, 32'h00001234);

    // 3: both ports reading continuously; last grant was port 0, so port 1 leads... unless fixed
`ifdef MEM_ARB_FIXED_PRIO_EN
    repeat (4) exp_q.push_back({1'b0, 1'b1, 16'h1111});
`else
    exp_q.push_back({1'b1, 1'b1, 16'h2222});
    exp_q.push_back({1'b0, 1'b1, 16'h1111});
    exp_q.push_back({1'b1, 1'b1, 16'h2222});
    exp_q.push_back({1'b0, 1'b1, 16'h1111});
`endif
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    set_port(1'b1, 1'b1, 1'b0, 16'h0041, 16'h0000);
    n = 0;
    last = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        if (n > 0) chk("rd_gap", cyc - last, 32'd4);
        last = cyc;
        n++;
      end
    end
    if (n < 4) note_fail("both_req_timeout");
    @(posedge clk); #1;
    set_port(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set_port(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);

    // 5: reset in the ACCESS cycle of a write aborts it
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b1, 16'h0030, 16'h5555);
    @(posedge clk); #1;
    reset = 1;
    set_port(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("rst_acc_wen",  {31'd0, mem_write_enable}, 32'd0);
    chk("rst_acc_ack0", {31'd0, ack0}, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("rst_acc_busy",  {31'd0, busy}, 32'd0);
    chk("rst_acc_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_acc_rdata0", {16'd0, rdata0}, 32'd0);
    chk("rst_acc_rdata1", {16'd0, rdata1}, 32'd0);
    access(1'b0, 1'b0, 16'h0030, 16'h0000, 16'hAAAA);

    // 6: req0 dropped (and inputs changed) one cycle after grant
    exp_q.push_back({1'b0, 1'b1, 16'h1111});
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    t0 = cyc;
    @(posedge clk); #1;
    set_port(1'b0, 1'b0, 1'b1, 16'h0041, 16'h9999);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (ack0) begin
        seen = 1;
        chk("drop_latency", cyc - t0, 32'd3);
      end
    end
    if (!seen) note_fail("drop_ack_timeout");
    chk("drop_no_write", {16'd0, mem[8'h41]}, 32'h00002222);

    repeat (5) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
